// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
//   Shares a 2-digit common-cathode 7-segment display between requester A
//   (key up/down counter) and requester B (status/alarm code). Ownership is
//   arbitrated once per frame with a minimum hold time, both digits are
//   scanned with a dead-time blanking window at the start of every slot, and
//   one byte is latched per frame so a digit pair never tears.
//
// Ports
//   Sys_CLK  in   1  system clock
//   Sys_RST  in   1  asynchronous, active-low reset
//   EN       in   1  display enable; low blanks the display, freezes arbitration
//   Req_A    in   1  requester A wants the display (level)
//   Data_A   in   8  A's byte: [7:4] high digit, [3:0] low digit
//   Req_B    in   1  requester B wants the display (level)
//   Data_B   in   8  B's byte, same format
//   Grant_A  out  1  A owns the display
//   Grant_B  out  1  B owns the display
//   COM      out  2  digit select: 01 low, 10 high, 00 none
//   SEG      out  8  segments [7:1]=a..g, [0]=DP, active high
// -----------------------------------------------------------------------------
module seg_display_arbiter #(
  parameter int DIV_MAX     = 5000,
  parameter int BLANK_CYC   = 8,
  parameter int HOLD_FRAMES = 100
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic       EN,
  input  logic       Req_A,
  input  logic [7:0] Data_A,
  input  logic       Req_B,
  input  logic [7:0] Data_B,
  output logic       Grant_A,
  output logic       Grant_B,
  output logic [1:0] COM,
  output logic [7:0] SEG
);

  localparam int TW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(DIV_MAX - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
  localparam logic [TW-1:0] BLANK_N    = TW'(BLANK_CYC);
  localparam logic [HW-1:0] HOLD_N     = HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_t;

  arb_t          st;
  arb_t          st_nxt;
  logic [TW-1:0] tick;
  logic          digit_hi;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] frames_done;
  logic [7:0]    frame;
  logic          boundary;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hFC;  4'h1: s = 8'h60;  4'h2: s = 8'hDA;  4'h3: s = 8'hF2;
      4'h4: s = 8'h66;  4'h5: s = 8'hB6;  4'h6: s = 8'hBE;  4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;  4'h9: s = 8'hF6;  4'hA: s = 8'hEE;  4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;  4'hD: s = 8'h7A;  4'hE: s = 8'h9E;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // The hold test counts the frame that is ending at this boundary as already
  // served, so an owner contested from its grant gives way after exactly
  // HOLD_FRAMES displayed frames.
  function automatic arb_t arb_next(input arb_t cur, input logic ra,
                                    input logic rb, input logic [HW-1:0] done);
    arb_t n;
    n = cur;
    case (cur)
      IDLE:    n = rb ? OWN_B : (ra ? OWN_A : IDLE);
      OWN_A: begin
        if (!ra)                     n = rb ? OWN_B : IDLE;
        else if (rb && done >= HOLD_N) n = OWN_B;
      end
      OWN_B: begin
        if (!rb)                     n = ra ? OWN_A : IDLE;
        else if (ra && done >= HOLD_N) n = OWN_A;
      end
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // Frame boundary: last blanking cycle before a low-digit slot.
  assign boundary    = EN && !digit_hi && (tick == BLANK_LAST);
  assign frames_done = (hold_cnt >= HOLD_N) ? HOLD_N : hold_cnt + 1'b1;
  assign st_nxt      = arb_next(st, Req_A, Req_B, frames_done);

  // ---- scan / arbitration / registered outputs ----
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      st       <= IDLE;
      hold_cnt <= '0;
      Grant_A  <= 1'b0;
      Grant_B  <= 1'b0;
      tick     <= '0;
      digit_hi <= 1'b0;
      COM      <= 2'b00;
      SEG      <= 8'h00;
    end else if (!EN) begin
      tick     <= '0;
      digit_hi <= 1'b0;
      COM      <= 2'b00;
      SEG      <= 8'h00;
    end else begin
      if (tick == TICK_LAST) begin
        tick     <= '0;
        digit_hi <= !digit_hi;
      end else begin
        tick <= tick + 1'b1;
      end

      if (tick < BLANK_N || st == IDLE) begin
        COM <= 2'b00;
        SEG <= 8'h00;
      end else if (!digit_hi) begin
        COM <= 2'b01;
        SEG <= hex7(frame[3:0]) | {7'b0, st == OWN_B};
      end else begin
        COM <= 2'b10;
        SEG <= hex7(frame[7:4]);
      end

      if (boundary) begin
        st       <= st_nxt;
        hold_cnt <= (st_nxt != st) ? '0 : frames_done;
        Grant_A  <= (st_nxt == OWN_A);
        Grant_B  <= (st_nxt == OWN_B);
      end
    end
  end

  // ---- frame latch: one coherent byte per frame from the new owner ----
  always_ff @(posedge Sys_CLK) begin
    if (boundary) frame <= (st_nxt == OWN_B) ? Data_B : Data_A;
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;

  localparam int DIV   = 20;
  localparam int BLANK = 4;
  localparam int HOLD  = 3;

  localparam logic [7:0] HEX [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6,
                                      8'hBE, 8'hE0, 8'hFE, 8'hF6, 8'hEE, 8'h3E,
                                      8'h9C, 8'h7A, 8'h9E, 8'h8E};

  logic       clk = 1'b0;
  logic       Sys_RST;
  logic       EN;
  logic       Req_A, Req_B;
  logic [7:0] Data_A, Data_B;
  logic       Grant_A, Grant_B;
  logic [1:0] COM;
  logic [7:0] SEG;

  seg_display_arbiter #(
    .DIV_MAX(DIV), .BLANK_CYC(BLANK), .HOLD_FRAMES(HOLD)
  ) dut (
    .Sys_CLK(clk), .Sys_RST(Sys_RST), .EN(EN),
    .Req_A(Req_A), .Data_A(Data_A), .Req_B(Req_B), .Data_B(Data_B),
    .Grant_A(Grant_A), .Grant_B(Grant_B), .COM(COM), .SEG(SEG)
  );

  always #5 clk = ~clk;

  // scoreboard: {Grant_A, Grant_B, COM, SEG}
  logic [11:0] sb_q[$];
  logic [11:0] last_exp;
  int n_checks = 0;
  int n_fail   = 0;

  // reference model: position within the enabled run, owner, frames served
  int         m_pos;
  int         m_own;     // 0 none, 1 A, 2 B
  int         m_frames;
  logic [7:0] m_frame;

  function automatic void model_step();
    int f, t, nw;
    bit lo;
    logic [1:0] com;
    logic [7:0] seg;
    logic [3:0] nib;
    logic [11:0] e;
    com = 2'b00;
    seg = 8'h00;
    if (!Sys_RST) begin
      m_pos = 0; m_own = 0; m_frames = 0;
    end else if (!EN) begin
      m_pos = 0;
    end else begin
      f  = m_pos % (2 * DIV);
      lo = (f < DIV);
      t  = f % DIV;
      if (t >= BLANK && m_own != 0) begin
        nib = lo ? m_frame[3:0] : m_frame[7:4];
        com = lo ? 2'b01 : 2'b10;
        seg = HEX[nib] | {7'b0, (lo && m_own == 2)};
      end
      if (f == BLANK - 1) begin
        nw = m_own;
        case (m_own)
          0: nw = Req_B ? 2 : (Req_A ? 1 : 0);
          1: if (!Req_A) nw = Req_B ? 2 : 0;
             else if (Req_B && m_frames + 1 >= HOLD) nw = 2;
          default: if (!Req_B) nw = Req_A ? 1 : 0;
             else if (Req_A && m_frames + 1 >= HOLD) nw = 1;
        endcase
        if (nw != m_own) m_frames = 0;
        else             m_frames++;
        m_own   = nw;
        m_frame = (nw == 2) ? Data_B : Data_A;
      end
      m_pos++;
    end
    e = {(m_own == 1), (m_own == 2), com, seg};
    sb_q.push_back(e);
    last_exp = e;
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
    end
    #2;
  endtask

  task automatic wait_com(input logic [1:0] c);
    for (int i = 0; i < 4 * DIV && last_exp[9:8] != c; i++) run(1);
  endtask

  task automatic compare(input string nm, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got ga=%b gb=%b com=%b seg=%h required ga=%b gb=%b com=%b seg=%h",
               nm, $time, got[11], got[10], got[9:8], got[7:0],
               exp[11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  // monitor: pops one expected vector per clock on the falling edge; a reset
  // asserted while the clock is high is checked for immediate effect
  initial begin
    logic [11:0] exp;
    forever begin
      @(negedge clk or negedge Sys_RST);
      if (clk) begin
        #1;
        compare("async_rst", {Grant_A, Grant_B, COM, SEG}, 12'h000);
        sb_q.delete();
      end else if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        compare("out", {Grant_A, Grant_B, COM, SEG}, exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Sys_RST = 1'b0; EN = 1'b0; Req_A = 1'b0; Req_B = 1'b0;
    Data_A = 8'h00; Data_B = 8'h00;
    m_pos = 0; m_own = 0; m_frames = 0; m_frame = 8'h00; last_exp = '0;
    run(3);
    Sys_RST = 1'b1;

    // idle display
    EN = 1'b1;
    run(200);

    // A alone
    Data_A = 8'h3C; Req_A = 1'b1;
    run(120);

    // data change during a low slot takes effect next frame
    wait_com(2'b01);
    Data_A = 8'h5A;
    run(120);

    // back to idle, then simultaneous requests: B first, alternation by hold
    Req_A = 1'b0;
    run(90);
    Data_B = 8'h7E; Req_A = 1'b1; Req_B = 1'b1;
    run(40 * 8);

    // owner drops mid-frame with the other side idle
    Req_A = 1'b0;
    run(50);
    wait_com(2'b01);
    Req_B = 1'b0;
    run(100);

    // asynchronous reset mid-show
    Req_A = 1'b1;
    run(60);
    wait_com(2'b10);
    Sys_RST = 1'b0;
    run(3);
    Sys_RST = 1'b1;
    run(80);

    // enable dropped mid-show, then restored
    wait_com(2'b01);
    EN = 1'b0;
    run(5);
    EN = 1'b1;
    run(80);

    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      EN     = ($urandom_range(0, 9) != 0);
      Req_A  = $urandom_range(0, 2) != 0;
      Req_B  = $urandom_range(0, 2) == 0;
      Data_A = 8'($urandom);
      Data_B = 8'($urandom);
      run($urandom_range(5, 90));
      Data_A = 8'($urandom);
      run($urandom_range(1, 30));
    end

    EN = 1'b1; Req_A = 1'b0; Req_B = 1'b0;
    run(10);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
